// File: rtl/hazard_forward_ctrl.sv
// Hazard detection and operand-forwarding controller that sits beside the ID stage.
// Optional performance counters are enabled with the HFU_PERF_CNT_EN macro.
module hazard_forward_ctrl #(
   parameter int unsigned NUM_FWD_STAGES = 3,
   parameter int unsigned REG_ADDR_W     = 5,
   localparam int unsigned SEL_W         = $clog2(NUM_FWD_STAGES + 1)
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [REG_ADDR_W-1:0]                id_rs1,
   input  logic [REG_ADDR_W-1:0]                id_rs2,
   input  logic                                 id_rs1_used,
   input  logic                                 id_rs2_used,
   input  logic                                 id_is_branch,
   input  logic [NUM_FWD_STAGES*REG_ADDR_W-1:0] fwd_rd,
   input  logic [NUM_FWD_STAGES-1:0]            fwd_we,
   input  logic [NUM_FWD_STAGES-1:0]            fwd_load,
   input  logic                                 mem_busy,
   output logic [SEL_W-1:0]                     mux_pa_sel,
   output logic [SEL_W-1:0]                     mux_pb_sel,
   output logic                                 pc_en,
   output logic                                 if_id_en,
   output logic                                 cumux_sel,
   output logic                                 pipe_en
`ifdef HFU_PERF_CNT_EN
   ,
   output logic [31:0]                          stall_cycles,
   output logic [31:0]                          freeze_cycles
`endif
);

   typedef enum logic {RUN, STALL} state_t;

   state_t           state_q, state_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [SEL_W-1:0] op_sel [2];
   logic [1:0]       op_need [2];
   logic [1:0]       bubble_c;

   // Per-operand forwarding source and the bubbles that source still needs
   always_comb begin
      logic [REG_ADDR_W-1:0] rs;
      logic                  used;
      logic                  hit;
      for (int op = 0; op < 2; op++) begin
         rs          = (op == 0) ? id_rs1 : id_rs2;
         used        = (op == 0) ? id_rs1_used : id_rs2_used;
         hit         = 1'b0;
         op_sel[op]  = '0;
         op_need[op] = 2'd0;
         for (int k = 0; k < int'(NUM_FWD_STAGES); k++) begin
            if (!hit && used && (rs != '0) && fwd_we[k] &&
                (fwd_rd[k*REG_ADDR_W +: REG_ADDR_W] == rs)) begin
               hit        = 1'b1;
               op_sel[op] = SEL_W'(k + 1);
               if (fwd_load[k]) begin
                  if (id_is_branch) op_need[op] = (k < 2) ? 2'(2 - k) : 2'd0;
                  else              op_need[op] = (k < 1) ? 2'd1 : 2'd0;
               end else begin
                  op_need[op] = (id_is_branch && (k < 1)) ? 2'd1 : 2'd0;
               end
            end
         end
      end
      bubble_c = (op_need[0] > op_need[1]) ? op_need[0] : op_need[1];
   end

   // Next state and pipeline control; freeze outranks any pending hazard
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pc_en      = 1'b1;
      if_id_en   = 1'b1;
      pipe_en    = 1'b1;
      cumux_sel  = 1'b0;
      mux_pa_sel = op_sel[0];
      mux_pb_sel = op_sel[1];
      if (reset) begin
         mux_pa_sel = '0;
         mux_pb_sel = '0;
         state_d    = RUN;
         cnt_d      = 2'd0;
      end else if (mem_busy) begin
         pc_en    = 1'b0;
         if_id_en = 1'b0;
         pipe_en  = 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (bubble_c != 2'd0) begin
                  pc_en     = 1'b0;
                  if_id_en  = 1'b0;
                  cumux_sel = 1'b1;
                  if (bubble_c == 2'd2) begin
                     state_d = STALL;
                     cnt_d   = 2'd1;
                  end
               end
            end
            STALL: begin
               pc_en     = 1'b0;
               if_id_en  = 1'b0;
               cumux_sel = 1'b1;
               if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
               if (cnt_q <= 2'd1) state_d = RUN;
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HFU_PERF_CNT_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] freeze_cycles_q, freeze_cycles_d;

   // Saturating event counters
   always_comb begin
      stall_cycles_d  = stall_cycles_q;
      freeze_cycles_d = freeze_cycles_q;
      if (cumux_sel && (stall_cycles_q != 32'hFFFF_FFFF))
         stall_cycles_d = stall_cycles_q + 32'd1;
      if (mem_busy && !reset && (freeze_cycles_q != 32'hFFFF_FFFF))
         freeze_cycles_d = freeze_cycles_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles_q  <= 32'd0;
         freeze_cycles_q <= 32'd0;
      end else begin
         stall_cycles_q  <= stall_cycles_d;
         freeze_cycles_q <= freeze_cycles_d;
      end
   end

   assign stall_cycles  = stall_cycles_q;
   assign freeze_cycles = freeze_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: a vector table for single-cycle behaviour
// plus hand-written sequences for the multi-cycle stall, freeze and reset cases.
module tb_hazard_forward_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  id_rs1, id_rs2;
   logic        id_rs1_used, id_rs2_used, id_is_branch;
   logic [14:0] fwd_rd;
   logic [2:0]  fwd_we, fwd_load;
   logic        mem_busy;
   logic [1:0]  mux_pa_sel, mux_pb_sel;
   logic        pc_en, if_id_en, cumux_sel, pipe_en;
`ifdef HFU_PERF_CNT_EN
   logic [31:0] stall_cycles, freeze_cycles;
`endif

   int n_vec = 0;
   int n_err = 0;

   hazard_forward_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rs1_used  (id_rs1_used),
      .id_rs2_used  (id_rs2_used),
      .id_is_branch (id_is_branch),
      .fwd_rd       (fwd_rd),
      .fwd_we       (fwd_we),
      .fwd_load     (fwd_load),
      .mem_busy     (mem_busy),
      .mux_pa_sel   (mux_pa_sel),
      .mux_pb_sel   (mux_pb_sel),
      .pc_en        (pc_en),
      .if_id_en     (if_id_en),
      .cumux_sel    (cumux_sel),
      .pipe_en      (pipe_en)
`ifdef HFU_PERF_CNT_EN
      ,
      .stall_cycles (stall_cycles),
      .freeze_cycles(freeze_cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [4:0]  rs1, rs2;
      logic        u1, u2, br;
      logic [14:0] rd;
      logic [2:0]  we, ld;
      logic        busy;
      logic [1:0]  pa, pb;
      logic        pc, cu, pe;
   } vec_t;

   function automatic logic [14:0] rd3(input logic [4:0] r0, input logic [4:0] r1,
                                        input logic [4:0] r2);
      return {r2, r1, r0};
   endfunction

   function automatic vec_t mk(input string name, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic br,
                               input logic [14:0] rd, input logic [2:0] we, input logic [2:0] ld,
                               input logic busy, input logic [1:0] pa, input logic [1:0] pb,
                               input logic pc, input logic cu, input logic pe);
      vec_t v;
      v.name = name; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.br = br;
      v.rd = rd; v.we = we; v.ld = ld; v.busy = busy;
      v.pa = pa; v.pb = pb; v.pc = pc; v.cu = cu; v.pe = pe;
      return v;
   endfunction

   task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic br, input logic [14:0] rd,
                        input logic [2:0] we, input logic [2:0] ld, input logic busy);
      id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
      id_is_branch = br; fwd_rd = rd; fwd_we = we; fwd_load = ld; mem_busy = busy;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Sample on the falling edge; {pa, pb, pc_en, if_id_en, cumux_sel, pipe_en}
   task automatic check_out(input string name, input logic [1:0] pa, input logic [1:0] pb,
                            input logic pc, input logic cu, input logic pe);
      logic [7:0] got, exp;
      @(negedge clk);
      got = {mux_pa_sel, mux_pb_sel, pc_en, if_id_en, cumux_sel, pipe_en};
      exp = {pa, pb, pc, pc, cu, pe};
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got {pa,pb,pc,ifid,cu,pipe}=%b required %b", name, got, exp);
      end
   endtask

`ifdef HFU_PERF_CNT_EN
   task automatic check_cnt(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d", name, got, exp);
      end
   endtask
`endif

   vec_t vecs[13];

   initial begin
      vecs[0]  = mk("prio_ex_over_mem", 5, 0, 1, 0, 0, rd3(5, 5, 0), 3'b011, 3'b000, 0, 1, 0, 1, 0, 1);
      vecs[1]  = mk("prio_mem_only",    5, 0, 1, 0, 0, rd3(5, 5, 0), 3'b010, 3'b000, 0, 2, 0, 1, 0, 1);
      vecs[2]  = mk("x0_no_fwd",        0, 0, 1, 0, 0, rd3(0, 0, 0), 3'b001, 3'b001, 0, 0, 0, 1, 0, 1);
      vecs[3]  = mk("load_use_ex",      0, 7, 0, 1, 0, rd3(7, 0, 0), 3'b001, 3'b001, 0, 0, 1, 0, 1, 1);
      vecs[4]  = mk("load_at_mem",      0, 7, 0, 1, 0, rd3(0, 7, 0), 3'b010, 3'b010, 0, 0, 2, 1, 0, 1);
      vecs[5]  = mk("unused_operand",   5, 0, 0, 0, 0, rd3(5, 0, 0), 3'b001, 3'b001, 0, 0, 0, 1, 0, 1);
      vecs[6]  = mk("br_alu_ex",        3, 0, 1, 0, 1, rd3(3, 0, 0), 3'b001, 3'b000, 0, 1, 0, 0, 1, 1);
      vecs[7]  = mk("br_load_mem",      3, 0, 1, 0, 1, rd3(0, 3, 0), 3'b010, 3'b010, 0, 2, 0, 0, 1, 1);
      vecs[8]  = mk("br_load_wb",       3, 0, 1, 0, 1, rd3(0, 0, 3), 3'b100, 3'b100, 0, 3, 0, 1, 0, 1);
      vecs[9]  = mk("two_ops_ex_wb",    4, 6, 1, 1, 0, rd3(4, 0, 6), 3'b101, 3'b000, 0, 1, 3, 1, 0, 1);
      vecs[10] = mk("busy_beats_hazard",0, 7, 0, 1, 0, rd3(7, 0, 0), 3'b001, 3'b001, 1, 0, 1, 0, 0, 0);
      vecs[11] = mk("no_we_no_fwd",     9, 9, 1, 1, 0, rd3(9, 9, 9), 3'b000, 3'b111, 0, 0, 0, 1, 0, 1);
      vecs[12] = mk("both_load_use",    9, 9, 1, 1, 0, rd3(9, 0, 0), 3'b001, 3'b001, 0, 1, 1, 0, 1, 1);

      // Reset forces outputs even with a live hazard on the inputs
      reset = 1'b1;
      drive(3, 0, 1, 0, 1, rd3(3, 0, 0), 3'b001, 3'b001, 0);
      next_cycle();
      check_out("reset_forced", 0, 0, 1, 0, 1);
      next_cycle();
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, '0, '0, '0, 0);
      check_out("after_reset_idle", 0, 0, 1, 0, 1);

      foreach (vecs[i]) begin
         next_cycle();
         drive(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].br,
               vecs[i].rd, vecs[i].we, vecs[i].ld, vecs[i].busy);
         check_out(vecs[i].name, vecs[i].pa, vecs[i].pb, vecs[i].pc, vecs[i].cu, vecs[i].pe);
      end

      // Branch after load: RUN bubble, STALL bubble, then forward from WB
      next_cycle();
      drive(3, 0, 1, 0, 1, rd3(3, 0, 0), 3'b001, 3'b001, 0);
      check_out("br_load_bubble1", 1, 0, 0, 1, 1);
      next_cycle();
      drive(3, 0, 1, 0, 1, rd3(0, 3, 0), 3'b010, 3'b010, 0);
      check_out("br_load_bubble2", 2, 0, 0, 1, 1);
      next_cycle();
      drive(3, 0, 1, 0, 1, rd3(0, 0, 3), 3'b100, 3'b000, 0);
      check_out("br_load_resume", 3, 0, 1, 0, 1);

      // Freeze mid-STALL, counters cleared by a fresh reset first
      next_cycle();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, '0, '0, '0, 0);
      next_cycle();
      reset = 1'b0;
      drive(3, 0, 1, 0, 1, rd3(3, 0, 0), 3'b001, 3'b001, 0);
      check_out("frz_first_bubble", 1, 0, 0, 1, 1);
      for (int c = 0; c < 4; c++) begin
         next_cycle();
         drive(3, 0, 1, 0, 1, rd3(0, 3, 0), 3'b010, 3'b010, 1);
         check_out($sformatf("frz_hold_%0d", c), 2, 0, 0, 0, 0);
      end
      next_cycle();
      drive(3, 0, 1, 0, 1, rd3(0, 3, 0), 3'b010, 3'b010, 0);
      check_out("frz_last_bubble", 2, 0, 0, 1, 1);
      next_cycle();
      drive(3, 0, 1, 0, 1, rd3(0, 0, 3), 3'b100, 3'b000, 0);
      check_out("frz_resume", 3, 0, 1, 0, 1);
`ifdef HFU_PERF_CNT_EN
      next_cycle();
      check_cnt("freeze_cycles", freeze_cycles, 32'd4);
      check_cnt("stall_cycles", stall_cycles, 32'd2);
`endif

      // Reset mid-STALL drops the pending bubble
      next_cycle();
      drive(3, 0, 1, 0, 1, rd3(3, 0, 0), 3'b001, 3'b001, 0);
      check_out("rst_stall_bubble1", 1, 0, 0, 1, 1);
      next_cycle();
      reset = 1'b1;
      drive(3, 0, 1, 0, 1, rd3(0, 3, 0), 3'b010, 3'b010, 0);
      check_out("rst_stall_forced", 0, 0, 1, 0, 1);
      next_cycle();
      reset = 1'b0;
      drive(3, 0, 1, 0, 0, rd3(0, 0, 3), 3'b100, 3'b000, 0);
      check_out("rst_stall_no_bubble", 3, 0, 1, 0, 1);
      next_cycle();
      check_out("rst_stall_still_run", 3, 0, 1, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Parametrised hazard-detection and forwarding controller for the RISC-V pipelined processor; sits beside the ID stage. Each cycle it selects per-operand forwarding sources from N downstream stages. It inserts a multi-cycle bubble sequence for load-use and branch-in-ID hazards, with a registered bubble counter. It freezes the whole pipeline while data memory is busy.

## Interface
Parameters:
- NUM_FWD_STAGES, 3, forwarding sources; stage 0 = EX, 1 = MEM, 2 = WB, higher = later.
- REG_ADDR_W, 5, register-address width.
- SEL_W, $clog2(NUM_FWD_STAGES+1), operand-select width (derived localparam).

Ports:
- clk  input  1  pipeline clock, all state on rising edge.
- reset  input  1  synchronous, active-high.
- id_rs1, id_rs2  input  REG_ADDR_W  ID source registers.
- id_rs1_used, id_rs2_used  input  1  source actually read by the ID instruction.
- id_is_branch  input  1  ID instruction resolves a branch/jump in ID (needs operands in ID).
- fwd_rd  input  NUM_FWD_STAGES*REG_ADDR_W  flattened destinations; stage k at [k*REG_ADDR_W +: REG_ADDR_W].
- fwd_we  input  NUM_FWD_STAGES  stage k writes the register file.
- fwd_load  input  NUM_FWD_STAGES  stage k holds a load whose data is not yet available.
- mem_busy  input  1  data memory not ready; freeze request.
- mux_pa_sel, mux_pb_sel  output  SEL_W  0 = register file, k+1 = stage k.
- pc_en, if_id_en  output  1  PC / IF-ID register load enables.
- cumux_sel  output  1  1 = inject NOP control word into ID/EX.
- pipe_en  output  1  ID/EX, EX/MEM, MEM/WB enables.

## Operation
- Forwarding (combinational, every cycle incl. STALL): for each operand, the lowest k with fwd_we[k]=1, fwd_rd[k]==rs and rs!=0 wins; sel=k+1. No match, rs==0, or operand unused gives sel=0.
- Bubble need B per used operand with winning stage k (0 if no match):
  - Non-branch: load gives max(0,1-k); ALU result gives 0.
  - Branch: load gives max(0,2-k); ALU result gives max(0,1-k).
  - B = max of both operands; B ∈ {0,1,2}.
- States: RUN, STALL; bubble counter cnt (2 bits).
- RUN, B=0: pc_en=if_id_en=pipe_en=1, cumux_sel=0.
- RUN, B>0: pc_en=if_id_en=0, cumux_sel=1, pipe_en=1.
  - If B=1, stay in RUN, so the hazard is re-evaluated next cycle.
  - If B=2, go to STALL with cnt=1.
- STALL: hazard evaluation is suppressed. Drive pc_en=if_id_en=0 and cumux_sel=1, then decrement cnt. At cnt==0 the next state is RUN.
- Freeze: mem_busy=1 overrides all states.
  - pc_en=if_id_en=pipe_en=0, cumux_sel=0.
  - State and cnt hold.
  - Forward selects still update.
- Reset: state=RUN, cnt=0.
  - While reset=1, outputs are forced: pc_en=if_id_en=pipe_en=1, cumux_sel=0, selects=0.
  - Reset asserted mid-STALL or mid-freeze abandons the remaining bubbles.

## Timing
- Select outputs have zero latency: combinational from the current-cycle inputs.
- The first bubble is asserted in the same cycle the hazard is detected. The second bubble of a B=2 sequence comes from the registered state in the next unfrozen cycle.
- A freeze during STALL delays the remaining bubbles 1:1 with mem_busy cycles; the bubble count is never lost or duplicated.
- mem_busy and a hazard in the same cycle: freeze wins. The hazard is evaluated in the first cycle mem_busy=0.
- Both operands hazarding with different B: the larger B is used, and only one bubble sequence is inserted.
- x0 as a destination never forwards or stalls, even with fwd_we=1 or fwd_load=1.

## Configuration
- HFU_PERF_CNT_EN defined: adds 32-bit outputs stall_cycles and freeze_cycles.
  - stall_cycles counts cycles with cumux_sel=1.
  - freeze_cycles counts cycles with mem_busy=1 and reset=0.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- HFU_PERF_CNT_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Priority: rs1=5; stage0 rd=5 we=1 load=0; stage1 rd=5 we=1 → mux_pa_sel=1, no bubble. With stage0 we=0 → sel=2.
- x0: rs1=0, stage0 rd=0 we=1 load=1 → sel=0, pc_en=1, cumux_sel=0.
- Load-use, non-branch: rs2=7 used, stage0 rd=7 load=1 → one cycle pc_en=0, cumux_sel=1. Next cycle, with the load at stage1 → mux_pb_sel=2, pc_en=1.
- Branch after load: id_is_branch=1, rs1=3, stage0 rd=3 load=1 → two consecutive bubble cycles (RUN→STALL→RUN), then pc_en=1 with sel=3.
- Freeze mid-STALL: assert mem_busy for 4 cycles while in STALL → pipe_en=0 and cumux_sel=0 for 4 cycles; exactly one remaining bubble after release. With HFU_PERF_CNT_EN, freeze_cycles=4 and stall_cycles=2.
- Reset mid-STALL: reset=1 for 1 cycle → state RUN, pc_en=1, no further bubbles.
